// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Brief    : Shared constants for the sequential multiplier: op codes, FSM
//            state encodings, NZCV flag indices and the iteration-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_UMULL = 2'b10;
    localparam logic [1:0] c_OP_SMULL = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_FIX  = 2'd2;
    localparam state_t c_DONE = 2'd3;

    // Flag bit positions are shared with the ALU NZCV packing.
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    function automatic int cycles(input int width, input int unroll);
        return width / unroll;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// ============================================================================
// Module   : mul_step
// Brief    : Combinational UNROLL-bit shift-add step of a right-shifting
//            accumulator multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_step #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic [2*WIDTH+UNROLL-1:0] i_acc_in,
    input  logic [WIDTH-1:0]          i_mcand,
    input  logic [UNROLL-1:0]         i_mplier_bits,
    output logic [2*WIDTH+UNROLL-1:0] o_acc_out
);

    localparam int c_SW = WIDTH + UNROLL;

    logic [c_SW-1:0]           w_pp;
    logic [c_SW-1:0]           w_sum;
    logic [2*WIDTH+UNROLL-1:0] w_cat;

    // Upper part stays below 2^WIDTH between steps, so WIDTH+UNROLL bits hold the sum.
    assign w_pp      = c_SW'(i_mcand) * c_SW'(i_mplier_bits);
    assign w_sum     = i_acc_in[2*WIDTH+UNROLL-1:WIDTH] + w_pp;
    assign w_cat     = {w_sum, i_acc_in[WIDTH-1:0]};
    assign o_acc_out = w_cat >> UNROLL;

endmodule
`default_nettype wire

// File: rtl/mul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_unit
// Brief    : Iterative MUL/UMULL/SMULL unit; sign-magnitude operands,
//            unsigned shift-add core, final negate for signed results.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int c_CYCLES = cycles(WIDTH, UNROLL);
    localparam int c_CNT_W  = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
    localparam int c_AW     = 2 * WIDTH + UNROLL;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_long;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_AW-1:0]    r_acc;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [3:0]         r_flags;

    logic [c_AW-1:0]    w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_neg_prod;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_is_smull;
    logic               w_run_last;
    logic [3:0]         w_flags;

    mul_step #(
        .WIDTH  (WIDTH),
        .UNROLL (UNROLL)
    ) u_step (
        .i_acc_in      (r_acc),
        .i_mcand       (r_mcand),
        .i_mplier_bits (r_mplier[UNROLL-1:0]),
        .o_acc_out     (w_step_acc)
    );

    assign w_is_smull = (op == c_OP_SMULL);
    // The most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_abs_a    = (w_is_smull && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign w_abs_b    = (w_is_smull && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    assign w_run_last = (r_cnt == c_CNT_W'(c_CYCLES - 1));
    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_neg_prod = (~w_prod) + (2*WIDTH)'(1);

    always_comb begin
        w_flags           = 4'b0000;
        w_flags[c_FLAG_N] = r_long ? w_prod[2*WIDTH-1] : w_prod[WIDTH-1];
        w_flags[c_FLAG_Z] = r_long ? (w_prod == '0) : (w_prod[WIDTH-1:0] == '0);
        w_flags[c_FLAG_C] = 1'b0;
        w_flags[c_FLAG_V] = 1'b0;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_RUN;
            c_RUN:   if (w_run_last) w_next = c_FIX;
            c_FIX:   w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_long   <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= (r_state == c_DONE);
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_long   <= (op == c_OP_UMULL) || w_is_smull;
                        r_neg    <= w_is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_RUN: begin
                    r_acc    <= w_step_acc;
                    r_mplier <= r_mplier >> UNROLL;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                end
                c_FIX: begin
                    if (r_neg) r_acc <= {{UNROLL{1'b0}}, w_neg_prod};
                end
                default: begin
                    r_lo    <= w_prod[WIDTH-1:0];
                    r_hi    <= r_long ? w_prod[2*WIDTH-1:WIDTH] : '0;
                    r_flags <= w_flags;
                end
            endcase
        end
    end

    assign busy      = (r_state == c_RUN) || (r_state == c_FIX);
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_unit
// Brief    : Directed self-checking bench for mul_seq_unit (UNROLL=1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_unit;

    localparam int c_W    = 32;
    localparam int c_LAT1 = 34;
    localparam int c_LAT4 = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [c_W-1:0]  a = '0;
    logic [c_W-1:0]  b = '0;
    logic            busy, done;
    logic [c_W-1:0]  lo, hi;
    logic [3:0]      flags;

    logic            start4 = 1'b0;
    logic [1:0]      op4 = 2'b00;
    logic [c_W-1:0]  a4 = '0;
    logic [c_W-1:0]  b4 = '0;
    logic            busy4, done4;
    logic [c_W-1:0]  lo4, hi4;
    logic [3:0]      flags4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_seq_unit #(.WIDTH(c_W), .UNROLL(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(lo), .result_hi(hi), .flags(flags)
    );

    mul_seq_unit #(.WIDTH(c_W), .UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4), .flags(flags4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the UNROLL=1 unit, scramble inputs after accept, then check.
    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic [3:0] efl);
        int lat;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; op = ~o;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check({tag, " latency"}, 64'(lat), 64'(c_LAT1));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " lo"}, 64'(lo), 64'(elo));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " flags"}, 64'(flags), 64'(efl));
        @(posedge clk); #1;
        check({tag, " done_pulse_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, ndone;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run32("mul_7x6",      2'b00, 32'd7,         32'd6,         32'h0,        32'd42,       4'b0000);
        run32("umull_max",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4'b1000);
        run32("smull_m1m1",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        4'b0000);
        run32("smull_minmin", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        4'b0000);
        run32("smull_minx1",  2'b11, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 4'b1000);
        run32("mul_zero_lo",  2'b00, 32'h10000,    32'h10000,    32'h0,        32'h0,        4'b0100);
        run32("rsvd_as_mul",  2'b01, 32'hFFFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFE, 4'b1000);

        // A start pulsed mid-RUN must be ignored.
        @(negedge clk);
        op = 2'b00; a = 32'h1234; b = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                @(negedge clk);
                a = 32'd3; b = 32'd3; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = i;
            end
        end
        check("midrun latency", 64'(lat), 64'(c_LAT1));
        check("midrun done_count", 64'(ndone), 64'd1);
        check("midrun lo", 64'(lo), 64'h12340);

        // Asynchronous reset in RUN aborts and clears outputs at once.
        @(negedge clk);
        op = 2'b10; a = 32'h0000FFFF; b = 32'h0000FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run32("mul_5x5_after_reset", 2'b00, 32'd5, 32'd5, 32'h0, 32'd25, 4'b0000);

        // UNROLL=4 instance.
        @(negedge clk);
        op4 = 2'b10; a4 = 32'h12345678; b4 = 32'h9ABCDEF0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) break;
        end
        check("u4 latency", 64'(lat), 64'(c_LAT4));
        check("u4 product", {hi4, lo4}, 64'h0B00EA4E_242D2080);
        check("u4 flags", 64'(flags4), 64'd0);
        check("u4 busy_at_done", 64'(busy4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
